univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised successor to the team's single-bit D flip-flop: a WIDTH-bit register with synchronous reset, clock enable and an 8-mode operation select.
- Modes: hold, logical shift right, shift left, arithmetic shift right, rotate right, rotate left, parallel load, clear.
- Tracks shifts since the last load/clear and pulses done after WIDTH shifts.
- Used as a serialiser/deserialiser and as a general datapath register in lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), width of shift_cnt; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous reset, active-high
- en  input  1  clock enable; 0 = hold all state
- mode  input  3  operation select (encodings below)
- ser_msb_in  input  1  serial bit entering the MSB on logical shift right
- ser_lsb_in  input  1  serial bit entering the LSB on shift left
- d_in  input  WIDTH  parallel load data
- q_out  output  WIDTH  register contents
- ser_lsb_out  output  1  equals q_out[0] (combinational from the register)
- ser_msb_out  output  1  equals q_out[WIDTH-1] (combinational from the register)
- shift_cnt  output  CNT_W  number of shift/rotate ops since the last load/clear/reset
- done  output  1  registered one-cycle pulse on the WIDTH-th shift

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst. All state updates on the rising edge of clk only.
- Priority: rst > en > mode.
- On rst=1 at an edge: q_out=0, shift_cnt=0, done=0, regardless of en/mode.
- en=0: q_out and shift_cnt hold; done=0.
- en=1, mode decode (q = current q_out):
  - 000 HOLD: q unchanged, cnt unchanged.
  - 001 SHR: q <= {ser_msb_in, q[W-1:1]}.
  - 010 SHL: q <= {q[W-2:0], ser_lsb_in}.
  - 011 ASR: q <= {q[W-1], q[W-1:1]}.
  - 100 ROR: q <= {q[0], q[W-1:1]}.
  - 101 ROL: q <= {q[W-2:0], q[W-1]}.
  - 110 LOAD: q <= d_in; cnt <= 0.
  - 111 CLEAR: q <= 0; cnt <= 0.
- Latency: every op is 1 cycle; the new value is visible on q_out after the edge. Serial outputs follow q_out with no extra delay.
- Counter, for shift ops (modes 001-101) with en=1:
  - If cnt == WIDTH-1: cnt <= 0 (wrap) and done <= 1 on the same edge.
  - Otherwise cnt <= cnt+1 and done <= 0.
- done is 0 on every cycle that does not complete the WIDTH-th shift, including HOLD, LOAD, CLEAR and en=0. It is never high for two consecutive cycles unless consecutive wraps occur, which requires WIDTH shifts between them.
- LOAD or CLEAR mid-count restarts counting from 0; no done is produced.
- rst mid-sequence discards the partial count.
- No X propagation: all registers are reset; mode is fully decoded.

Test Plan (WIDTH=8):
- Reset precedence: rst=1, en=1, mode=LOAD, d_in=8'hA5 for 1 edge -> q_out=8'h00, shift_cnt=0, done=0.
- Load/shift: LOAD 8'hA5 -> 8'hA5. Then SHR with ser_msb_in=1 -> 8'hD2, ser_lsb_out=0. Then SHL with ser_lsb_in=0 -> 8'hA4, shift_cnt=2.
- Rotate/arith: LOAD 8'h81; ROR -> 8'hC0; ROL -> 8'h81. LOAD 8'h80; ASR -> 8'hC0; ASR -> 8'hE0.
- Done/wrap: LOAD 8'h01, then 8 ROL ops with one en=0 cycle after the 4th.
  - shift_cnt stays at 4 during the en=0 cycle.
  - After the 8th ROL: q_out=8'h01, done=1 for exactly that cycle, shift_cnt=0.
  - 9th ROL -> done=0, shift_cnt=1.
- Mid-op reset/load: after 3 SHL ops assert rst -> q_out=0, shift_cnt=0, done=0. After 5 shifts issue LOAD 8'h3C -> shift_cnt=0, and no done after 3 further shifts.
- Hold/clear: from 8'h5A, HOLD with en=1 for 3 cycles -> q_out=8'h5A and shift_cnt unchanged. CLEAR -> q_out=8'h00, shift_cnt=0.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold, shifts, rotates, parallel load and clear,
// plus a shift counter that pulses done on every WIDTH-th shift since the last load/clear.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_msb_in,
    input  logic             ser_lsb_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out,
    output logic             ser_lsb_out,
    output logic             ser_msb_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeShr   = 3'b001;
    localparam logic [2:0] ModeShl   = 3'b010;
    localparam logic [2:0] ModeAsr   = 3'b011;
    localparam logic [2:0] ModeRor   = 3'b100;
    localparam logic [2:0] ModeRol   = 3'b101;
    localparam logic [2:0] ModeLoad  = 3'b110;
    localparam logic [2:0] ModeClear = 3'b111;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             is_shift;

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        is_shift = 1'b0;
        if (en) begin
            unique case (mode)
                ModeHold:  q_d = q_q;
                ModeShr:   begin q_d = {ser_msb_in, q_q[WIDTH-1:1]};     is_shift = 1'b1; end
                ModeShl:   begin q_d = {q_q[WIDTH-2:0], ser_lsb_in};     is_shift = 1'b1; end
                ModeAsr:   begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};   is_shift = 1'b1; end
                ModeRor:   begin q_d = {q_q[0], q_q[WIDTH-1:1]};         is_shift = 1'b1; end
                ModeRol:   begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};   is_shift = 1'b1; end
                ModeLoad:  begin q_d = d_in;            cnt_d = '0; end
                ModeClear: begin q_d = '0;              cnt_d = '0; end
                default:   q_d = q_q;
            endcase
            // Counter wraps on the WIDTH-th shift and flags it for exactly that cycle.
            if (is_shift) begin
                if (cnt_q == CntLast) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q_out       = q_q;
    assign ser_lsb_out = q_q[0];
    assign ser_msb_out = q_q[WIDTH-1];
    assign shift_cnt   = cnt_q;
    assign done        = done_q;

endmodule
